floppy_track_streamer: RTL and testbench

FLOPPY_TRACK_STREAMER -- requirements
Module: floppy_track_streamer

---
 rtl/floppy_track_streamer_if.sv | 37 +++
 rtl/floppy_track_streamer.sv | 242 ++++++++++++++++++++++++
 tb/tb_floppy_track_streamer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/floppy_track_streamer_if.sv
// ---------------------------------------------------------------------------
// floppy_track_streamer_if
//
// Byte-wide read port between the track streamer and the memory that holds
// the track images.
//
//   memReadReq   streamer -> memory  request, held high until memReadAck
//   memReadAddr  streamer -> memory  byte address, stable while memReadReq=1
//   memReadAck   memory -> streamer  one-cycle pulse, data valid this cycle
//   memReadData  memory -> streamer  fetched byte
//
// Modports: master = streamer side, slave = memory side.
// ---------------------------------------------------------------------------
interface floppy_track_streamer_if #(
  parameter int ADDR_W = 22
) ();

  logic              memReadReq;
  logic [ADDR_W-1:0] memReadAddr;
  logic              memReadAck;
  logic [7:0]        memReadData;

  modport master (
    output memReadReq,
    output memReadAddr,
    input  memReadAck,
    input  memReadData
  );

  modport slave (
    input  memReadReq,
    input  memReadAddr,
    output memReadAck,
    output memReadData
  );

endinterface

// File: rtl/floppy_track_streamer.sv
// ---------------------------------------------------------------------------
// floppy_track_streamer
//
// Streams a floppy track image from memory to the IWM read latch at disk
// byte rate. Bytes are prefetched into a 2-entry FIFO and delivered once per
// BYTE_CLOCKS cycles of clk8. In sync mode, delivery also waits for the IWM
// to signal (advanceDriveHead) that it consumed the previous byte.
//
// Ports
//   clk8              sole clock, rising edge
//   reset             asynchronous, active-high
//   motorOn           drive spinning; gates fetch starts and deliveries
//   trackLoad         one-cycle pulse: restart streaming at trackBase
//   trackBase         track image byte address (sampled on trackLoad)
//   trackLen          bytes per track, 0 = empty (sampled on trackLoad)
//   syncMode          1 = delivery paced by advanceDriveHead
//   advanceDriveHead  one-cycle pulse from the IWM
//   mem               memory read port (master side)
//   readData          last delivered disk byte
//   newByteReady      one-cycle pulse aligned with a new readData value
//   underrun          sticky: a delivery slot found the FIFO empty
// ---------------------------------------------------------------------------
module floppy_track_streamer #(
  parameter int BYTE_CLOCKS = 128,
  parameter int ADDR_W      = 22
) (
  input  logic                  clk8,
  input  logic                  reset,
  input  logic                  motorOn,
  input  logic                  trackLoad,
  input  logic [ADDR_W-1:0]     trackBase,
  input  logic [12:0]           trackLen,
  input  logic                  syncMode,
  input  logic                  advanceDriveHead,
  floppy_track_streamer_if.master mem,
  output logic [7:0]            readData,
  output logic                  newByteReady,
  output logic                  underrun
);

  // Timer must hold BYTE_CLOCKS-1; keep at least one bit for tiny values.
  localparam int TW = (BYTE_CLOCKS > 2) ? $clog2(BYTE_CLOCKS) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(BYTE_CLOCKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2   // request outstanding for a track that was replaced
  } fetch_state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  fetch_state_e      state_q,    state_d;
  logic              req_q,      req_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [7:0]        rdata_q,    rdata_d;
  logic              nbr_q,      nbr_d;
  logic              underrun_q, underrun_d;
  logic [1:0]        count_q,    count_d;
  logic              wr_ptr_q,   wr_ptr_d;
  logic              rd_ptr_q,   rd_ptr_d;
  logic [12:0]       offset_q,   offset_d;
  logic [ADDR_W-1:0] base_q,     base_d;
  logic [12:0]       len_q,      len_d;
  logic              adv_q,      adv_d;     // advanceDriveHead seen since last delivery
  logic              first_q,    first_d;   // next delivery is ungated
  logic [TW-1:0]     timer_q,    timer_d;

  logic [7:0]        fifo_mem [2];

  // Decoded events for this cycle
  logic push;
  logic pop;
  logic gate_open;
  logic slot;
  logic deliver_slot;

  // A trackLoad cycle belongs to the new track: acks are discarded and no
  // delivery slot is honoured.
  assign push         = (state_q == S_REQ) && mem.memReadAck && !trackLoad;
  assign gate_open    = !syncMode || adv_q || first_q;
  assign slot         = motorOn && (timer_q == '0);
  assign deliver_slot = slot && gate_open && !trackLoad;
  assign pop          = deliver_slot && (count_q != 2'd0);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    nbr_d      = 1'b0;
    underrun_d = underrun_q;
    count_d    = count_q + 2'(push) - 2'(pop);
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    offset_d   = offset_q;
    base_d     = base_q;
    len_d      = len_q;
    adv_d      = adv_q;
    first_d    = first_q;
    timer_d    = timer_q;

    // Byte timer: counts while the motor spins; at zero it waits for the
    // gate and reloads only when the slot is actually taken.
    if (motorOn) begin
      if (timer_q != '0) begin
        timer_d = timer_q - TW'(1);
      end else if (gate_open) begin
        timer_d = TIMER_RELOAD;
      end
    end

    // Delivery slot
    if (pop) begin
      rdata_d = fifo_mem[rd_ptr_q];
      nbr_d   = 1'b1;
      first_d = 1'b0;
      adv_d   = 1'b0;
    end else if (deliver_slot) begin
      underrun_d = 1'b1;
    end

    // A pulse coinciding with a delivery counts toward the next byte.
    if (advanceDriveHead) begin
      adv_d = 1'b1;
    end

    // Fetch FSM
    case (state_q)
      S_IDLE: begin
        if (motorOn && (len_q != 13'd0) && (count_q < 2'd2) && !trackLoad) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = base_q + ADDR_W'(offset_q);
        end
      end
      S_REQ: begin
        if (trackLoad) begin
          // Bus request cannot be withdrawn; finish it and drop the byte.
          if (mem.memReadAck) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (mem.memReadAck) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          offset_d = (offset_q == len_q - 13'd1) ? 13'd0 : offset_q + 13'd1;
        end
      end
      S_DRAIN: begin
        if (mem.memReadAck) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Track (re)load overrides FIFO, offset, timer and status.
    if (trackLoad) begin
      count_d    = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      offset_d   = 13'd0;
      base_d     = trackBase;
      len_d      = trackLen;
      underrun_d = 1'b0;
      first_d    = 1'b1;
      timer_d    = TIMER_RELOAD;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk8 or posedge reset) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      rdata_q    <= 8'd0;
      nbr_q      <= 1'b0;
      underrun_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      offset_q   <= 13'd0;
      base_q     <= '0;
      len_q      <= 13'd0;
      adv_q      <= 1'b0;
      first_q    <= 1'b1;
      timer_q    <= TIMER_RELOAD;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      nbr_q      <= nbr_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      offset_q   <= offset_d;
      base_q     <= base_d;
      len_q      <= len_d;
      adv_q      <= adv_d;
      first_q    <= first_d;
      timer_q    <= timer_d;
    end
  end

  // NOTE: FIFO storage has no reset; count_q marks which entries are valid,
  // so stale contents are never read.
  always_ff @(posedge clk8) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem.memReadData;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem.memReadReq  = req_q;
  assign mem.memReadAddr = addr_q;
  assign readData        = rdata_q;
  assign newByteReady    = nbr_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_floppy_track_streamer.sv
// ---------------------------------------------------------------------------
// tb_floppy_track_streamer
//
// Self-checking bench: a memory responder with programmable ack latency,
// queues of expected fetch addresses and delivered bytes, and one task per
// scenario.
// ---------------------------------------------------------------------------
module tb_floppy_track_streamer;

  localparam int ADDR_W = 22;

  logic              clk8;
  logic              reset;
  logic              motorOn;
  logic              trackLoad;
  logic [ADDR_W-1:0] trackBase;
  logic [12:0]       trackLen;
  logic              syncMode;
  logic              advanceDriveHead;
  logic [7:0]        readData;
  logic              newByteReady;
  logic              underrun;

  floppy_track_streamer_if #(.ADDR_W(ADDR_W)) mif ();

  floppy_track_streamer #(.BYTE_CLOCKS(128), .ADDR_W(ADDR_W)) dut (
    .clk8             (clk8),
    .reset            (reset),
    .motorOn          (motorOn),
    .trackLoad        (trackLoad),
    .trackBase        (trackBase),
    .trackLen         (trackLen),
    .syncMode         (syncMode),
    .advanceDriveHead (advanceDriveHead),
    .mem              (mif),
    .readData         (readData),
    .newByteReady     (newByteReady),
    .underrun         (underrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state
  logic [7:0]        exp_data [$];
  logic [ADDR_W-1:0] exp_addr [$];
  bit                addr_chk = 1'b0;
  int                nbr_count = 0;
  int                req_rise  = 0;
  int                deliv_cyc [$];
  int                cyc = 0;

  // Memory responder state
  int                ack_lat  = 3;
  int                resp_cnt = 0;
  logic [ADDR_W-1:0] resp_addr;

  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  initial begin
    clk8 = 1'b0;
    forever #5 clk8 = ~clk8;
  end

  initial forever begin
    @(posedge clk8);
    cyc++;
  end

  // Memory: acks ack_lat cycles after seeing a request; an ack once started
  // is always delivered, even if the request vanished (reset mid-fetch).
  initial begin
    mif.memReadAck  = 1'b0;
    mif.memReadData = 8'd0;
    forever begin
      @(posedge clk8);
      #1;
      mif.memReadAck = 1'b0;
      if (resp_cnt == 0 && mif.memReadReq) begin
        resp_addr = mif.memReadAddr;
        resp_cnt  = 1;
      end else if (resp_cnt > 0) begin
        resp_cnt++;
      end
      if (resp_cnt > 0 && resp_cnt >= ack_lat) begin
        mif.memReadAck  = 1'b1;
        mif.memReadData = mem_byte(resp_addr);
        resp_cnt        = 0;
      end
    end
  end

  // Output monitor: sampled on the falling edge.
  initial begin
    logic              req_prev;
    logic [ADDR_W-1:0] addr_prev;
    logic [7:0]        e;
    logic [ADDR_W-1:0] ea;
    req_prev  = 1'b0;
    addr_prev = '0;
    forever begin
      @(negedge clk8);
      if (!reset) begin
        if (newByteReady) begin
          nbr_count++;
          deliv_cyc.push_back(cyc);
          n_checks++;
          if (exp_data.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte: readData=%02h, none expected", readData);
          end else begin
            e = exp_data.pop_front();
            if (readData !== e) begin
              n_fail++;
              $display("FAIL byte_data: readData=%02h, required %02h", readData, e);
            end
          end
        end
        if (mif.memReadReq && !req_prev) begin
          req_rise++;
          if (addr_chk) begin
            n_checks++;
            if (exp_addr.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_fetch: addr=%06h, none expected", mif.memReadAddr);
            end else begin
              ea = exp_addr.pop_front();
              if (mif.memReadAddr !== ea) begin
                n_fail++;
                $display("FAIL fetch_addr: addr=%06h, required %06h", mif.memReadAddr, ea);
              end
            end
          end
        end
        if (mif.memReadReq && req_prev) begin
          n_checks++;
          if (mif.memReadAddr !== addr_prev) begin
            n_fail++;
            $display("FAIL addr_stable: addr=%06h, required %06h", mif.memReadAddr, addr_prev);
          end
        end
      end
      req_prev  = mif.memReadReq;
      addr_prev = mif.memReadAddr;
    end
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk8);
    #1;
  endtask

  task automatic load_track(input logic [ADDR_W-1:0] b, input logic [12:0] l);
    @(posedge clk8);
    #1;
    trackBase = b;
    trackLen  = l;
    trackLoad = 1'b1;
    @(posedge clk8);
    #1;
    trackLoad = 1'b0;
  endtask

  // Quiesce, reset and clear the scoreboard before each scenario.
  task automatic start_test(input int lat);
    int guard;
    motorOn          = 1'b0;
    syncMode         = 1'b0;
    advanceDriveHead = 1'b0;
    guard = 0;
    while ((resp_cnt != 0 || mif.memReadReq) && guard < 400) begin
      tick(1);
      guard++;
    end
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    ack_lat  = lat;
    addr_chk = 1'b0;
    exp_data.delete();
    exp_addr.delete();
    deliv_cyc.delete();
    nbr_count = 0;
    req_rise  = 0;
  endtask

  task automatic wait_deliveries(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (nbr_count < target && n < budget) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (nbr_count < target) begin
      n_fail++;
      $display("FAIL %s_timeout: deliveries=%0d, required %0d", name, nbr_count, target);
    end
  endtask

  task automatic wait_req(input int budget, input string name);
    int n;
    n = 0;
    while (!mif.memReadReq && n < budget) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (!mif.memReadReq) begin
      n_fail++;
      $display("FAIL %s_req_timeout: memReadReq=0, required 1", name);
    end
  endtask

  task automatic expect_reset_outputs(input string name);
    n_checks++;
    if (mif.memReadReq !== 1'b0 || mif.memReadAddr !== '0 || readData !== 8'd0 ||
        newByteReady !== 1'b0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: req=%b addr=%06h data=%02h nbr=%b underrun=%b, required all 0",
               name, mif.memReadReq, mif.memReadAddr, readData, newByteReady, underrun);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    tick(2);
    expect_reset_outputs("reset_held");
    reset = 1'b0;
    tick(3);
    expect_reset_outputs("reset_released");
  endtask

  task automatic test_free_run();
    start_test(3);
    addr_chk = 1'b1;
    for (int k = 0; k < 24; k++) begin
      exp_addr.push_back(ADDR_W'(22'h1000 + (k % 4)));
      exp_data.push_back(mem_byte(ADDR_W'(22'h1000 + (k % 4))));
    end
    motorOn = 1'b1;
    load_track(22'h1000, 13'd4);
    wait_deliveries(8, 8 * 128 + 300, "free_run");
    for (int i = 1; i < 8 && i < deliv_cyc.size(); i++) begin
      n_checks++;
      if (deliv_cyc[i] - deliv_cyc[i-1] != 128) begin
        n_fail++;
        $display("FAIL byte_period: interval=%0d, required 128", deliv_cyc[i] - deliv_cyc[i-1]);
      end
    end
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL free_run_underrun: underrun=%b, required 0", underrun);
    end
  endtask

  task automatic test_single_byte_wrap();
    start_test(3);
    addr_chk = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_addr.push_back(22'h5000);
      exp_data.push_back(mem_byte(22'h5000));
    end
    motorOn = 1'b1;
    load_track(22'h5000, 13'd1);
    wait_deliveries(4, 4 * 128 + 300, "wrap_one");
  endtask

  task automatic test_sync_mode();
    start_test(2);
    exp_data.push_back(mem_byte(22'h3000));
    exp_data.push_back(mem_byte(22'h3001));
    motorOn  = 1'b1;
    syncMode = 1'b1;
    load_track(22'h3000, 13'd8);
    tick(600);
    n_checks++;
    if (nbr_count != 1) begin
      n_fail++;
      $display("FAIL sync_one_byte: deliveries=%0d, required 1", nbr_count);
    end
    advanceDriveHead = 1'b1;
    tick(1);
    advanceDriveHead = 1'b0;
    wait_deliveries(2, 3, "sync_advance");
  endtask

  task automatic test_underrun();
    start_test(200);
    for (int k = 0; k < 4; k++) exp_data.push_back(mem_byte(ADDR_W'(22'h4000 + k)));
    motorOn = 1'b1;
    load_track(22'h4000, 13'd4);
    tick(135);
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_set: underrun=%b, required 1", underrun);
    end
    n_checks++;
    if (nbr_count != 0) begin
      n_fail++;
      $display("FAIL underrun_no_pulse: deliveries=%0d, required 0", nbr_count);
    end
    load_track(22'h4000, 13'd4);
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_clear: underrun=%b, required 0", underrun);
    end
  endtask

  task automatic test_drain();
    start_test(20);
    addr_chk = 1'b1;
    exp_addr.push_back(22'h1000);
    for (int k = 0; k < 8; k++) exp_addr.push_back(ADDR_W'(22'h2000 + (k % 4)));
    for (int k = 0; k < 3; k++) exp_data.push_back(mem_byte(ADDR_W'(22'h2000 + k)));
    motorOn = 1'b1;
    load_track(22'h1000, 13'd4);
    wait_req(10, "drain");
    tick(5);
    load_track(22'h2000, 13'd4);
    n_checks++;
    if (mif.memReadReq !== 1'b1 || mif.memReadAddr !== 22'h1000) begin
      n_fail++;
      $display("FAIL drain_hold: req=%b addr=%06h, required 1 / 001000",
               mif.memReadReq, mif.memReadAddr);
    end
    wait_deliveries(2, 400, "drain");
  endtask

  task automatic test_reset_mid_fetch();
    start_test(10);
    motorOn = 1'b1;
    load_track(22'h1000, 13'd4);
    wait_req(10, "reset_mid");
    tick(3);
    reset = 1'b1;
    #1;
    n_checks++;
    if (mif.memReadReq !== 1'b0 || mif.memReadAddr !== '0) begin
      n_fail++;
      $display("FAIL reset_async: req=%b addr=%06h, required 0 / 000000",
               mif.memReadReq, mif.memReadAddr);
    end
    tick(1);
    reset = 1'b0;
    req_rise  = 0;
    nbr_count = 0;
    tick(15);
    expect_reset_outputs("reset_mid_after_ack");
    tick(140);
    n_checks++;
    if (underrun !== 1'b1 || nbr_count != 0 || req_rise != 0) begin
      n_fail++;
      $display("FAIL reset_fifo_empty: underrun=%b deliveries=%0d fetches=%0d, required 1/0/0",
               underrun, nbr_count, req_rise);
    end
  endtask

  task automatic test_empty_track();
    start_test(3);
    motorOn = 1'b1;
    load_track(22'h6000, 13'd0);
    tick(100);
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_early: underrun=%b, required 0", underrun);
    end
    tick(40);
    n_checks++;
    if (underrun !== 1'b1 || req_rise != 0 || nbr_count != 0) begin
      n_fail++;
      $display("FAIL empty_track: underrun=%b fetches=%0d deliveries=%0d, required 1/0/0",
               underrun, req_rise, nbr_count);
    end
  endtask

  initial begin
    reset            = 1'b1;
    motorOn          = 1'b0;
    trackLoad        = 1'b0;
    trackBase        = '0;
    trackLen         = 13'd0;
    syncMode         = 1'b0;
    advanceDriveHead = 1'b0;

    test_reset();
    test_free_run();
    test_single_byte_wrap();
    test_sync_mode();
    test_underrun();
    test_drain();
    test_reset_mid_fetch();
    test_empty_track();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
